alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational datapath ALU.
- Operand width is a parameter (multiple of 4 bits), with a start/done handshake and registered result and flags.
- Binary ops take one execute cycle. Decimal (BCD) add and subtract are nibble-serial: one digit per cycle, so BCD extends to any number of digits.
- Sits between the operand latches (A, B) and the ALU hold register; the control FSM drives `start` and waits for `done`.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
- DIGITS, WIDTH/4, number of BCD digits; derived, do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only when ready=1
- op  in  3  operation (alu_op_t)
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- carry_in  in  1  carry in (for subtract: 1 = no borrow)
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in EXEC
- done  out  1  one-cycle pulse, results valid
- result  out  WIDTH  registered result, held until next accepted start
- carry_out  out  1  registered carry out
- overflow  out  1  registered signed overflow
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]

Behaviour:
- Reset: state=IDLE; ready=1, busy=0, done=0; result=0; all flags 0; digit counter=0. Reset mid-EXEC aborts the operation with no done pulse.
- FSM states: IDLE, EXEC, DONE.
  - IDLE/DONE + start → EXEC. At that edge: latch a_in, b_in, op, carry_in; counter=0; clear partial result.
  - EXEC, binary op → DONE after one edge.
  - EXEC, decimal op → DONE after DIGITS edges (digit i processed at edge i, LSD first).
  - DONE → IDLE if start=0 (done high for exactly one cycle).
- Latency from the start-sampling edge to the done cycle: 2 cycles for binary ops, DIGITS+1 for decimal ops. Back-to-back start in the DONE cycle is accepted; throughput is then 2 or DIGITS+1 cycles per op.
- start while busy is ignored; latched operands are unaffected by input changes during EXEC.
- Ops (binary):
  - ADD: {c,r} = A + B + cin.
  - SUB: {c,r} = A + ~B + cin.
  - AND, EOR, OR: r = A op B; carry_out=0.
  - SHR (rotate right through carry): r = {cin, A[W-1:1]}, carry_out = A[0].
  - overflow: ADD/SUB only, (A[msb]^r[msb]) & (B'[msb]^r[msb]), where B' is the actual adder operand. overflow=0 for all other ops.
- Ops (decimal, per digit, with running carry/borrow register):
  - DADD: s = a_d + b_d + c (5-bit). If s>9: digit = s+6 (4-bit truncate), c=1; else digit = s[3:0], c=0. Initial c=carry_in.
  - DSUB: s = a_d − b_d − bw (signed). If s<0: digit = s+10 (4-bit), bw=1; else bw=0. Initial bw=~carry_in; final carry_out=~bw.
  - Invalid digits (>9) are not flagged; the formulas apply as written, truncated to 4 bits.
  - overflow=0.
- zero and negative are computed from the final result for every op, registered at the DONE transition.
- result and flags update only at the DONE-entry edge; the partial result is internal until then.

Decomposition:
- Package alu_pkg:
  - alu_op_t, 3-bit: ADD=0, SUB=1, AND=2, EOR=3, OR=4, SHR=5, DADD=6, DSUB=7.
  - alu_state_t: IDLE, EXEC, DONE.
  - BCD_MAX_DIGIT=9, BCD_ADJ_ADD=6, BCD_ADJ_SUB=10.
- Sub-module bcd_digit_step: combinational; inputs a_d[3:0], b_d[3:0], cin, sub; outputs d[3:0], cout. Instantiated once, with the digit selected by the counter.
- Top module: FSM, operand/partial registers, binary ALU.

Test Plan:
- WIDTH=8, ADD 0x7F+0x01, cin=0 → result=0x80, overflow=1, negative=1, carry_out=0; done exactly 2 cycles after start, busy for 1 cycle.
- WIDTH=8, DADD 0x58+0x46, cin=0 → result=0x04, carry_out=1; done at cycle 3. DSUB 0x12−0x21, cin=1 → result=0x91, carry_out=0.
- WIDTH=16, DADD 0x9999+0x0001, cin=0 → result=0x0000, carry_out=1, zero=1; done at cycle 5.
- SHR A=0x81, cin=1 → result=0xC0, carry_out=1. AND 0xF0&0x0F → zero=1, carry_out=0.
- Pulse start during EXEC of a WIDTH=16 DADD with changed a_in → ignored, original result produced. Then assert start in the DONE cycle → second op accepted with no IDLE gap.
- Assert rst at EXEC digit 2 → next cycle: ready=1, result=0, flags 0, no done pulse. A fresh op then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, state and BCD constants shared by the sequential ALU
package alu_pkg;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      AND  = 3'd2,
      EOR  = 3'd3,
      OR   = 3'd4,
      SHR  = 3'd5,
      DADD = 3'd6,
      DSUB = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } alu_state_t;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   localparam logic [3:0] BCD_ADJ_ADD   = 4'd6;
   localparam logic [3:0] BCD_ADJ_SUB   = 4'd10;

endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit of add (carry) or subtract (borrow), combinational
module bcd_digit_step
   import alu_pkg::*;
(
   input  logic [3:0] a_d,
   input  logic [3:0] b_d,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] d,
   output logic       cout
);

   logic [4:0] s_add;
   logic [4:0] s_sub;
   logic       add_gt;

   // a-b-bw spans -16..15, so bit 4 is the sign of the difference
   assign s_add  = {1'b0, a_d} + {1'b0, b_d} + {4'b0, cin};
   assign s_sub  = {1'b0, a_d} - {1'b0, b_d} - {4'b0, cin};
   assign add_gt = s_add > {1'b0, BCD_MAX_DIGIT};
   assign cout   = sub ? s_sub[4] : add_gt;
   assign d      = sub ? (s_sub[4] ? s_sub[3:0] + BCD_ADJ_SUB : s_sub[3:0])
                       : (add_gt ? s_add[3:0] + BCD_ADJ_ADD : s_add[3:0]);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake; binary ops in one cycle, BCD nibble-serial
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             carry_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;

   alu_state_t       state_q;
   alu_op_t          op_q;
   logic [WIDTH-1:0] a_q, b_q, part_q, result_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, carry_q, ovf_q, zero_q, neg_q;
   logic [WIDTH-1:0] b_op, bin_r, part_d, fin_r;
   logic [WIDTH:0]   sum;
   logic [3:0]       dig_d;
   logic             dig_c, bin_c, bin_v, is_arith, is_dec, last, fin_c;

   bcd_digit_step u_step (
      .a_d  (a_q[cnt_q*4 +: 4]),
      .b_d  (b_q[cnt_q*4 +: 4]),
      .cin  (c_q),
      .sub  (op_q == DSUB),
      .d    (dig_d),
      .cout (dig_c)
   );

   always_comb begin
      is_arith = op_q == ADD || op_q == SUB;
      is_dec   = op_q == DADD || op_q == DSUB;
      b_op     = op_q == SUB ? ~b_q : b_q;
      sum      = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_q};
      bin_r    = op_q == AND ? a_q & b_q :
                 op_q == EOR ? a_q ^ b_q :
                 op_q == OR  ? a_q | b_q :
                 op_q == SHR ? {c_q, a_q[WIDTH-1:1]} : sum[WIDTH-1:0];
      bin_c    = op_q == SHR ? a_q[0] : is_arith & sum[WIDTH];
      bin_v    = is_arith & (a_q[WIDTH-1] ^ bin_r[WIDTH-1]) & (b_op[WIDTH-1] ^ bin_r[WIDTH-1]);
      part_d   = part_q;
      part_d[cnt_q*4 +: 4] = dig_d;
      last     = !is_dec || cnt_q == CW'(DIGITS - 1);
      fin_r    = is_dec ? part_d : bin_r;
      fin_c    = is_dec ? dig_c ^ (op_q == DSUB) : bin_c;
   end

   // c_q holds carry for add and borrow for DSUB, so DSUB starts from ~carry_in
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= ADD;
         a_q      <= '0;
         b_q      <= '0;
         part_q   <= '0;
         cnt_q    <= '0;
         c_q      <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
      end else if (state_q != EXEC) begin
         if (start) begin
            state_q <= EXEC;
            op_q    <= alu_op_t'(op);
            a_q     <= a_in;
            b_q     <= b_in;
            c_q     <= carry_in ^ (op == DSUB);
            cnt_q   <= '0;
            part_q  <= '0;
         end else begin
            state_q <= IDLE;
         end
      end else begin
         part_q <= part_d;
         c_q    <= dig_c;
         cnt_q  <= cnt_q + 1'b1;
         if (last) begin
            state_q  <= DONE;
            result_q <= fin_r;
            carry_q  <= fin_c;
            ovf_q    <= bin_v;
            zero_q   <= fin_r == '0;
            neg_q    <= fin_r[WIDTH-1];
         end
      end
   end

   assign ready     = state_q != EXEC;
   assign busy      = state_q == EXEC;
   assign done      = state_q == DONE;
   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: 8- and 16-bit alu_seq instances on shared stimulus, checked against an arithmetic model
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, carry_in;
   logic [2:0]  op;
   logic [15:0] a_in, b_in;
   logic        r8, b8, d8, c8, v8, z8, n8;
   logic        r16, b16, d16, c16, v16, z16, n16;
   logic [7:0]  res8;
   logic [15:0] res16;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in[7:0]), .b_in(b_in[7:0]),
      .carry_in(carry_in), .ready(r8), .busy(b8), .done(d8), .result(res8),
      .carry_out(c8), .overflow(v8), .zero(z8), .negative(n8)
   );

   alu_seq #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
      .carry_in(carry_in), .ready(r16), .busy(b16), .done(d16), .result(res16),
      .carry_out(c16), .overflow(v16), .zero(z16), .negative(n16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // returns {carry, overflow, zero, negative, result[15:0]} computed with plain integer arithmetic
   function automatic logic [19:0] model(input int w, input logic [2:0] o, input logic [15:0] a_r,
                                         input logic [15:0] b_r, input logic cin);
      longint m, a, b, bb, t, sa, sb, r;
      int     cc, s, ad, bd, dg;
      bit     c, v;
      m = longint'(1) << w;
      a = longint'(a_r) % m;
      b = longint'(b_r) % m;
      c = 0;
      v = 0;
      r = 0;
      case (o)
         3'd0, 3'd1: begin
            bb = (o == 3'd1) ? m - 1 - b : b;
            t  = a + bb + longint'(cin);
            r  = t % m;
            c  = t >= m;
            sa = a  >= m / 2 ? a  - m : a;
            sb = bb >= m / 2 ? bb - m : bb;
            t  = sa + sb + longint'(cin);
            v  = (t < -(m / 2)) || (t >= m / 2);
         end
         3'd2: r = a & b;
         3'd3: r = a ^ b;
         3'd4: r = a | b;
         3'd5: begin
            r = (cin ? m / 2 : 0) + a / 2;
            c = (a % 2) == 1;
         end
         default: begin
            cc = (o == 3'd6) ? int'(cin) : int'(!cin);
            for (int i = 0; i < w / 4; i++) begin
               ad = int'((a >> (4 * i)) & 15);
               bd = int'((b >> (4 * i)) & 15);
               if (o == 3'd6) begin
                  s = ad + bd + cc;
                  if (s > 9) begin dg = (s + 6) & 15; cc = 1; end
                  else begin dg = s; cc = 0; end
               end else begin
                  s = ad - bd - cc;
                  if (s < 0) begin dg = (s + 10) & 15; cc = 1; end
                  else begin dg = s; cc = 0; end
               end
               r = r + (longint'(dg) << (4 * i));
            end
            c = (o == 3'd6) ? (cc == 1) : (cc == 0);
         end
      endcase
      return {c, v, r == 0, ((r >> (w - 1)) & 1) == 1, 16'(r)};
   endfunction

   function automatic int latency(input int w, input logic [2:0] o);
      return o >= 3'd6 ? w / 4 + 1 : 2;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one operation on both widths; inputs are scrambled during EXEC to prove they were latched
   task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic [19:0] e8, e16;
      int p8 = 0, p16 = 0, t8 = -1, t16 = -1;
      e8  = model(8, o, a, b, cin);
      e16 = model(16, o, a, b, cin);
      start = 1'b1; op = o; a_in = a; b_in = b; carry_in = cin;
      for (int n = 1; n <= 7; n++) begin
         tick();
         start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); carry_in = 1'($urandom); op = 3'($urandom);
         if (n == 1) check($sformatf("busy op%0d", o), {r8, b8, r16, b16}, 4'b0101);
         if (d8)  begin p8++;  t8 = n;  end
         if (d16) begin p16++; t16 = n; end
      end
      check($sformatf("lat8 op%0d", o), t8, latency(8, o));
      check($sformatf("lat16 op%0d", o), t16, latency(16, o));
      check($sformatf("pulses op%0d", o), {p8[3:0], p16[3:0]}, 8'h11);
      check($sformatf("out8 op%0d a=%h b=%h c=%b", o, a, b, cin), {c8, v8, z8, n8, 8'h00, res8}, e8);
      check($sformatf("out16 op%0d a=%h b=%h c=%b", o, a, b, cin), {c16, v16, z16, n16, res16}, e16);
   endtask

   initial begin
      int pd;
      rst = 1'b1; start = 1'b0; op = 3'd0; a_in = '0; b_in = '0; carry_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset8", {r8, b8, d8, c8, v8, z8, n8, res8}, {7'b1000000, 8'h00});
      check("reset16", {r16, b16, d16, c16, v16, z16, n16, res16}, {7'b1000000, 16'h0000});

      run_op(ADD, 16'h007F, 16'h0001, 1'b0);
      check("add7f", {c8, v8, z8, n8, res8}, {4'b0101, 8'h80});
      run_op(DADD, 16'h0058, 16'h0046, 1'b0);
      check("dadd58", {c8, res8}, {1'b1, 8'h04});
      run_op(DSUB, 16'h0012, 16'h0021, 1'b1);
      check("dsub12", {c8, res8}, {1'b0, 8'h91});
      run_op(DADD, 16'h9999, 16'h0001, 1'b0);
      check("dadd9999", {c16, z16, res16}, {2'b11, 16'h0000});
      run_op(SHR, 16'h0081, 16'h0000, 1'b1);
      check("shr81", {c8, res8}, {1'b1, 8'hC0});
      run_op(AND, 16'h00F0, 16'h000F, 1'b0);
      check("andf0", {z8, c8}, 2'b10);
      run_op(SUB, 16'h8000, 16'h0001, 1'b1);
      run_op(EOR, 16'hA5A5, 16'h5A5A, 1'b0);
      run_op(OR, 16'h0000, 16'h0000, 1'b1);

      // start during EXEC is ignored; start in the DONE cycle is taken immediately
      start = 1'b1; op = DADD; a_in = 16'h1234; b_in = 16'h0567; carry_in = 1'b0;
      tick();
      a_in = 16'h9999;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("no early done", d16, 1'b0);
      tick();
      check("busy-start ignored", {d16, c16, res16}, {1'b1, model(16, DADD, 16'h1234, 16'h0567, 1'b0)[19], model(16, DADD, 16'h1234, 16'h0567, 1'b0)[15:0]});
      start = 1'b1; op = ADD; a_in = 16'h1111; b_in = 16'h2222; carry_in = 1'b0;
      tick();
      start = 1'b0;
      check("b2b accepted", b16, 1'b1);
      tick();
      check("b2b result", {d16, res16}, {1'b1, 16'h3333});
      tick();

      // reset at digit 2 of a 16-bit DADD
      start = 1'b1; op = DADD; a_in = 16'h4321; b_in = 16'h1111; carry_in = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst mid-exec", {r16, b16, d16, c16, v16, z16, n16, res16}, {7'b1000000, 16'h0000});
      pd = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (d16) pd++;
      end
      check("no done after abort", pd, 0);
      run_op(DADD, 16'h4321, 16'h1111, 1'b0);

      for (int k = 0; k < 40; k++)
         run_op(3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
